// File: rtl/logic_stage_pkg.sv
// Shared widths, state encoding and flag payload for the logic result stage.
package logic_stage_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned RD_W  = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic sign;
        logic parity;
    } flags_t;

endpackage

// File: rtl/result_flags.sv
// Combinational zero/sign/parity flags for a logic-unit result word.
module result_flags
    import logic_stage_pkg::*;
#(
    parameter int unsigned WIDTH = logic_stage_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] result_i,
    output flags_t           flags_o
);

    always_comb begin
        flags_o        = '0;
        flags_o.zero   = (result_i == '0);
        flags_o.sign   = result_i[WIDTH-1];
        flags_o.parity = ^result_i;
    end

endmodule

// File: rtl/logic_result_stage.sv
// Two-entry skid buffer between the logic unit and writeback; flags are
// computed once at capture and travel with the entry.
module logic_result_stage
    import logic_stage_pkg::*;
#(
    parameter int unsigned WIDTH = logic_stage_pkg::WIDTH,
    parameter int unsigned RD_W  = logic_stage_pkg::RD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [RD_W-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_zero,
    output logic             out_sign,
    output logic             out_parity
);

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] head_result_q;
    logic [RD_W-1:0]  head_rd_q;
    flags_t           head_flags_q;
    logic [WIDTH-1:0] skid_result_q;
    logic [RD_W-1:0]  skid_rd_q;
    flags_t           skid_flags_q;

    flags_t           in_flags;
    logic             accept;
    logic             pop;

    result_flags #(
        .WIDTH (WIDTH)
    ) u_result_flags (
        .result_i (in_result),
        .flags_o  (in_flags)
    );

    assign accept = in_valid && in_ready_q;
    assign pop    = out_valid_q && out_ready;

    // Head holds the oldest entry; skid only fills when the head is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            head_result_q <= '0;
            head_rd_q     <= '0;
            head_flags_q  <= '0;
            skid_result_q <= '0;
            skid_rd_q     <= '0;
            skid_flags_q  <= '0;
        end else if (flush) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        head_result_q <= in_result;
                        head_rd_q     <= in_rd;
                        head_flags_q  <= in_flags;
                        out_valid_q   <= 1'b1;
                        state_q       <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_result_q <= in_result;
                        head_rd_q     <= in_rd;
                        head_flags_q  <= in_flags;
                    end else if (accept) begin
                        skid_result_q <= in_result;
                        skid_rd_q     <= in_rd;
                        skid_flags_q  <= in_flags;
                        in_ready_q    <= 1'b0;
                        state_q       <= TWO;
                    end else if (pop) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_result_q <= skid_result_q;
                        head_rd_q     <= skid_rd_q;
                        head_flags_q  <= skid_flags_q;
                        in_ready_q    <= 1'b1;
                        state_q       <= ONE;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = head_result_q;
    assign out_rd     = head_rd_q;
    assign out_zero   = head_flags_q.zero;
    assign out_sign   = head_flags_q.sign;
    assign out_parity = head_flags_q.parity;

endmodule

// File: tb/tb_logic_result_stage.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_logic_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_zero;
    logic        out_sign;
    logic        out_parity;

    always #5 clk = ~clk;

    logic_result_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_zero   (out_zero),
        .out_sign   (out_sign),
        .out_parity (out_parity)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } ent_t;

    ent_t q[$];
    logic m_ready;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   dut_pops = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare the present outputs with the model, apply one cycle of inputs, advance.
    task automatic cycle(input logic rst, input logic fl, input logic iv,
                         input logic [31:0] res, input logic [4:0] rd, input logic ordy);
        logic acc;
        logic pp;
        ent_t e;
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("in_ready", 64'(in_ready), 64'(m_ready));
        if (q.size() != 0) begin
            check("out_result", 64'(out_result), 64'(q[0].res));
            check("out_rd", 64'(out_rd), 64'(q[0].rd));
            check("out_zero", 64'(out_zero), 64'(q[0].res == 32'd0));
            check("out_sign", 64'(out_sign), 64'(q[0].res >= 32'h8000_0000));
            check("out_parity", 64'(out_parity), 64'($countones(q[0].res) % 2));
        end
        if (out_valid && ordy) dut_pops++;

        rst_n     = rst;
        flush     = fl;
        in_valid  = iv;
        in_result = res;
        in_rd     = rd;
        out_ready = ordy;

        if (!rst) begin
            q.delete();
            m_ready = 1'b0;
        end else if (fl) begin
            q.delete();
            m_ready = 1'b1;
        end else begin
            acc = iv && m_ready;
            pp  = (q.size() != 0) && ordy;
            if (pp) void'(q.pop_front());
            if (acc) begin
                e.res = res;
                e.rd  = rd;
                q.push_back(e);
            end
            m_ready = (q.size() < 2);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 5'd0, ordy);
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_rd     = '0;
        out_ready = 1'b0;
        m_ready   = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // reset state, then release
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
        idle(1'b1);

        // single pass with zero result
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0000, 5'd3, 1'b1);
        idle(1'b1);

        // flag patterns
        cycle(1'b1, 1'b0, 1'b1, 32'h8000_0001, 5'd1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0007, 5'd2, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // backpressure: A, B fill both slots, C held until space opens
        cycle(1'b1, 1'b0, 1'b1, 32'h11, 5'd4, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h22, 5'd5, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'h33, 5'd6, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h33, 5'd6, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 32'h33, 5'd6, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // full-rate streaming
        base = dut_pops;
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 1'b1, 32'(i + 1), 5'(i), 1'b1);
        check("stream_pops", 64'(dut_pops - base), 64'd99);
        idle(1'b1);
        idle(1'b1);

        // flush while full with a simultaneous offer
        cycle(1'b1, 1'b0, 1'b1, 32'hAAAA_0001, 5'd7, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'hAAAA_0002, 5'd8, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'hAAAA_0003, 5'd9, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // one-cycle reset while holding one entry
        cycle(1'b1, 1'b0, 1'b1, 32'h5555_0001, 5'd10, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h5555_0002, 5'd11, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            logic r;
            logic f;
            r = ($urandom_range(0, 99) != 0);
            f = ($urandom_range(0, 39) == 0);
            cycle(r, f, 1'($urandom_range(0, 3) != 0), $urandom(),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 2) != 0));
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
